multiplicador_seq: RTL and testbench

- Parametrised sequential shift-and-add multiplier. Successor to the combinational 8x8 array multiplier.
- Generalised to any operand width and adds a runtime signed/unsigned mode.
- Uses a valid/ready handshake on both input and output, so it sits between register stages in the datapath.
- Trades area for latency: one partial product is accumulated per clock.

---
 rtl/multiplicador_seq.sv | 131 +++++++++++++
 tb/tb_multiplicador_seq.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiplicador_seq.sv
// multiplicador_seq: sequential shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
// One partial product is accumulated per clock, so a product takes WIDTH cycles.
// Signed operands are handled by multiplying their magnitudes and negating the
// final sum when the operand signs differ.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_valid     A, B, signed_mode are valid
//   in_ready     operands can be accepted (IDLE only)
//   A, B         multiplicand / multiplier, WIDTH bits
//   signed_mode  1 = two's-complement operands and product, 0 = unsigned
//   busy         computation in progress
//   out_valid    P holds a valid product
//   out_ready    downstream accepts P
//   P            product, 2*WIDTH bits
module multiplicador_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic               signed_mode,
    output logic               busy,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] P
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int PW    = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_reg, state_next;
    logic [PW-1:0]    mcand_reg, mcand_next;
    logic [PW-1:0]    acc_reg, acc_next;
    logic [PW-1:0]    p_reg, p_next;
    logic [WIDTH-1:0] mplier_reg, mplier_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             neg_reg, neg_next;

    logic             accept;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [PW-1:0]    sum;
    logic [CNT_W-1:0] cnt_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            mcand_reg  <= '0;
            acc_reg    <= '0;
            p_reg      <= '0;
            mplier_reg <= '0;
            cnt_reg    <= '0;
            neg_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            mcand_reg  <= mcand_next;
            acc_reg    <= acc_next;
            p_reg      <= p_next;
            mplier_reg <= mplier_next;
            cnt_reg    <= cnt_next;
            neg_reg    <= neg_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        mcand_next  = mcand_reg;
        acc_next    = acc_reg;
        p_next      = p_reg;
        mplier_next = mplier_reg;
        cnt_next    = cnt_reg;
        neg_next    = neg_reg;

        accept = in_valid && (state_reg == IDLE);

        // Operand inputs are only looked at on an accepting cycle, so X on
        // A/B/signed_mode elsewhere never reaches the datapath. Negating the
        // most negative value yields 2^(WIDTH-1), which fits as unsigned.
        mag_a = '0;
        mag_b = '0;
        if (accept) begin
            mag_a = (signed_mode && A[WIDTH-1]) ? -A : A;
            mag_b = (signed_mode && B[WIDTH-1]) ? -B : B;
        end

        sum     = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
        cnt_inc = cnt_reg + CNT_W'(1);

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    mcand_next  = {{WIDTH{1'b0}}, mag_a};
                    mplier_next = mag_b;
                    acc_next    = '0;
                    cnt_next    = '0;
                    neg_next    = signed_mode && (A[WIDTH-1] ^ B[WIDTH-1]);
                    state_next  = CALC;
                end
            end
            CALC: begin
                acc_next    = sum;
                mcand_next  = mcand_reg << 1;
                mplier_next = mplier_reg >> 1;
                cnt_next    = cnt_inc;
                // Fixed-latency: always WIDTH steps, even once mplier is zero.
                // Negating a zero sum gives zero, so no negative zero appears.
                if (cnt_inc == CNT_W'(WIDTH)) begin
                    p_next     = neg_reg ? -sum : sum;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign in_ready  = (state_reg == IDLE);
    assign busy      = (state_reg == CALC);
    assign out_valid = (state_reg == DONE);
    assign P         = p_reg;

endmodule

// File: tb/tb_multiplicador_seq.sv
// Testbench for multiplicador_seq: instances at WIDTH 8, 16 and 4 sharing one
// clock and reset. Expected products come from a sign-extend-and-multiply
// reference model and are queued when stimulus is driven, then popped when
// the DUT presents a product.
module tb_multiplicador_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        iv8, ir8, sm8, busy8, ov8, or8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;
    logic        iv16, ir16, sm16, busy16, ov16, or16;
    logic [15:0] a16, b16;
    logic [31:0] p16;
    logic        iv4, ir4, sm4, busy4, ov4, or4;
    logic [3:0]  a4, b4;
    logic [7:0]  p4;

    multiplicador_seq #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .A(a8), .B(b8),
        .signed_mode(sm8), .busy(busy8), .out_valid(ov8), .out_ready(or8), .P(p8));
    multiplicador_seq #(.WIDTH(16)) u16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .A(a16), .B(b16),
        .signed_mode(sm16), .busy(busy16), .out_valid(ov16), .out_ready(or16), .P(p16));
    multiplicador_seq #(.WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .A(a4), .B(b4),
        .signed_mode(sm4), .busy(busy4), .out_valid(ov4), .out_ready(or4), .P(p4));

    int checks = 0;
    int failures = 0;
    int n_acc = 0;
    int n_out = 0;
    logic [63:0] sb8[$];
    logic [63:0] sb16[$];
    logic [63:0] sb4[$];

    typedef struct packed {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        sm;
        logic [15:0] p;
    } vec8_t;
    vec8_t vecs [11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: sign- or zero-extend to 64 bits, multiply, keep 2*w bits.
    function automatic logic [63:0] model(input int w, input logic [31:0] a,
                                          input logic [31:0] b, input logic sm);
        logic [63:0] xa, xb, mask;
        mask = (64'd1 << w) - 64'd1;
        xa = 64'(a) & mask;
        xb = 64'(b) & mask;
        if (sm && a[w-1]) xa = xa | ~mask;
        if (sm && b[w-1]) xb = xb | ~mask;
        return (xa * xb) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    task automatic pop_check8(input string name);
        logic [63:0] e;
        check({name, "_outstanding"}, 64'(sb8.size() != 0), 64'd1);
        if (sb8.size() != 0) begin
            e = sb8.pop_front();
            check(name, 64'(p8), e);
            n_out++;
            $display("txn w8 %s P=%h exp=%h", name, p8, e[15:0]);
        end
    endtask

    // Full W8 transaction: accept, exact latency, optional back-pressure, pop.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic sm,
                       input logic [15:0] exp, input int hold);
        int w;
        sb8.push_back(64'(exp));
        a8 = a; b8 = b; sm8 = sm; iv8 = 1'b1;
        w = 0;
        @(negedge clk);
        while (!ir8 && w < 50) begin @(negedge clk); w++; end
        check("w8_accept", 64'(ir8), 64'd1);
        @(posedge clk); #1;
        iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom);
        w = 0;
        while (!ov8 && w < 50) begin @(posedge clk); #1; w++; end
        check("w8_latency", 64'(w), 64'd8);
        repeat (hold) begin @(posedge clk); #1; end
        or8 = 1'b1;
        @(negedge clk);
        pop_check8("w8_P");
        @(posedge clk); #1;
        or8 = 1'b0;
        check("w8_back_idle", 64'({ov8, ir8, busy8}), 64'b010);
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic sm,
                        input logic [31:0] exp, input int hold);
        int w;
        logic [63:0] e;
        sb16.push_back(64'(exp));
        a16 = a; b16 = b; sm16 = sm; iv16 = 1'b1;
        w = 0;
        @(negedge clk);
        while (!ir16 && w < 50) begin @(negedge clk); w++; end
        check("w16_accept", 64'(ir16), 64'd1);
        @(posedge clk); #1;
        iv16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
        w = 0;
        while (!ov16 && w < 60) begin @(posedge clk); #1; w++; end
        check("w16_latency", 64'(w), 64'd16);
        repeat (hold) begin @(posedge clk); #1; end
        or16 = 1'b1;
        @(negedge clk);
        e = (sb16.size() != 0) ? sb16.pop_front() : 64'hDEAD;
        check("w16_P", 64'(p16), e);
        $display("txn w16 a=%h b=%h sm=%0d P=%h exp=%h", a, b, sm, p16, e[31:0]);
        @(posedge clk); #1;
        or16 = 1'b0;
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic sm,
                       input logic [7:0] exp, input int hold);
        int w;
        logic [63:0] e;
        sb4.push_back(64'(exp));
        a4 = a; b4 = b; sm4 = sm; iv4 = 1'b1;
        w = 0;
        @(negedge clk);
        while (!ir4 && w < 50) begin @(negedge clk); w++; end
        check("w4_accept", 64'(ir4), 64'd1);
        @(posedge clk); #1;
        iv4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
        w = 0;
        while (!ov4 && w < 50) begin @(posedge clk); #1; w++; end
        check("w4_latency", 64'(w), 64'd4);
        repeat (hold) begin @(posedge clk); #1; end
        or4 = 1'b1;
        @(negedge clk);
        e = (sb4.size() != 0) ? sb4.pop_front() : 64'hDEAD;
        check("w4_P", 64'(p4), e);
        $display("txn w4 a=%h b=%h sm=%0d P=%h exp=%h", a, b, sm, p4, e[7:0]);
        @(posedge clk); #1;
        or4 = 1'b0;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ra, rb;
        logic        rs;
        int          w;

        vecs[0]  = '{a: 8'hFD, b: 8'h07, sm: 1'b1, p: 16'hFFEB};
        vecs[1]  = '{a: 8'h80, b: 8'h80, sm: 1'b1, p: 16'h4000};
        vecs[2]  = '{a: 8'h80, b: 8'h7F, sm: 1'b1, p: 16'hC080};
        vecs[3]  = '{a: 8'hFD, b: 8'h07, sm: 1'b0, p: 16'h06EB};
        vecs[4]  = '{a: 8'hFF, b: 8'hFF, sm: 1'b0, p: 16'hFE01};
        vecs[5]  = '{a: 8'h00, b: 8'hFF, sm: 1'b1, p: 16'h0000};
        vecs[6]  = '{a: 8'hFF, b: 8'h00, sm: 1'b0, p: 16'h0000};
        vecs[7]  = '{a: 8'hFF, b: 8'hFF, sm: 1'b1, p: 16'h0001};
        vecs[8]  = '{a: 8'h7F, b: 8'h7F, sm: 1'b1, p: 16'h3F01};
        vecs[9]  = '{a: 8'h01, b: 8'h80, sm: 1'b1, p: 16'hFF80};
        vecs[10] = '{a: 8'h0C, b: 8'h0D, sm: 1'b0, p: 16'h009C};

        rst_n = 1'b0;
        iv8 = 0; or8 = 0; a8 = 0; b8 = 0; sm8 = 0;
        iv16 = 0; or16 = 0; a16 = 0; b16 = 0; sm16 = 0;
        iv4 = 0; or4 = 0; a4 = 0; b4 = 0; sm4 = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 64'({ir8, busy8, ov8, p8}), 64'({3'b100, 16'h0000}));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table-driven W8 vectors, a little back-pressure on some.
        for (int i = 0; i < 11; i++) begin
            op8(vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].p, i % 3);
        end

        // Reset in the middle of a calculation.
        sb8.push_back(64'd600);
        a8 = 8'd200; b8 = 8'd3; sm8 = 1'b0; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid_busy", 64'(busy8), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset", 64'({ir8, busy8, ov8, p8}), 64'({3'b100, 16'h0000}));
        sb8.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        op8(8'd255, 8'd255, 1'b0, 16'hFE01, 0);

        // Back-pressure: product held, in_ready low, new operands ignored.
        sb8.push_back(64'd35);
        a8 = 8'd5; b8 = 8'd7; sm8 = 1'b0; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        w = 0;
        while (!ov8 && w < 50) begin @(posedge clk); #1; w++; end
        check("bp_latency", 64'(w), 64'd8);
        a8 = 8'd1; b8 = 8'd1; sm8 = 1'b0; iv8 = 1'b1; or8 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_hold", 64'({ov8, ir8, p8}), 64'({2'b10, sb8[0][15:0]}));
        end
        or8 = 1'b1;
        @(posedge clk); #1;
        or8 = 1'b0;
        check("bp_release", 64'({ov8, ir8, p8}), 64'({2'b01, 16'd35}));
        pop_check8("bp_P");
        sb8.push_back(model(8, 32'd1, 32'd1, 1'b0));
        @(posedge clk); #1;
        iv8 = 1'b0;
        check("bp_second_accept", 64'(busy8), 64'd1);
        w = 0;
        while (!ov8 && w < 50) begin @(posedge clk); #1; w++; end
        check("bp_second_latency", 64'(w), 64'd8);
        or8 = 1'b1;
        @(negedge clk);
        pop_check8("bp_second_P");
        @(posedge clk); #1;
        or8 = 1'b0;

        // Other widths: directed corners then random sequences.
        op16(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 0);
        op16(16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001, 1);
        op16(16'h8000, 16'h8000, 1'b1, 32'h40000000, 0);
        op4(4'h8, 4'h8, 1'b1, 8'h40, 0);
        op4(4'h7, 4'h8, 1'b1, 8'hC8, 2);
        op4(4'hF, 4'hF, 1'b0, 8'hE1, 0);
        for (int i = 0; i < 120; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom);
            op16(ra, rb, rs, 32'(model(16, 32'(ra), 32'(rb), rs)), $urandom_range(0, 3));
            op4(ra[3:0], rb[3:0], rs, 8'(model(4, 32'(ra[3:0]), 32'(rb[3:0]), rs)),
                $urandom_range(0, 3));
        end

        // W8 soak with random in_valid / out_ready; handshakes sampled at negedge.
        sb8.delete();
        n_acc = 0;
        n_out = 0;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            iv8 = ($urandom_range(0, 2) != 0);
            a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom);
            or8 = 1'($urandom);
            @(negedge clk);
            if (iv8 && ir8) begin
                sb8.push_back(model(8, 32'(a8), 32'(b8), sm8));
                n_acc++;
            end
            if (ov8 && or8) pop_check8("soak_P");
        end
        @(posedge clk); #1;
        iv8 = 1'b0;
        or8 = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (ov8) pop_check8("drain_P");
            @(posedge clk); #1;
        end
        or8 = 1'b0;
        check("soak_lost", 64'(sb8.size()), 64'd0);
        check("soak_counts", 64'(n_out), 64'(n_acc));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
